// File: rtl/dmem_responder.sv
// In-order data-memory responder: request FIFO, fixed-latency access FSM, byte-enabled word storage.
// Optional misalignment check enabled by defining DMEM_RESPONDER_ALIGN_CHK_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH_MEM  = 10,
  parameter int WIDTH_TAG  = 3,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_data,
  input  logic [3:0]            i_req_be,
  input  logic [WIDTH_TAG-1:0]  i_req_tag,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_data,
  output logic                  o_rsp_we,
  output logic [WIDTH_TAG-1:0]  o_rsp_tag,
  output logic                  o_rsp_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DEPTH = 1 << WIDTH_MEM;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [3:0]     CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

  typedef struct packed {
    logic                   we;
    logic [WIDTH_MEM+1:0]   addr;
    logic [31:0]            data;
    logic [3:0]             be;
    logic [WIDTH_TAG-1:0]   tag;
  } req_t;

  req_t                 fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 push, pop, empty, full, access, misaligned;
  req_t                 req_in, wrk;
  state_t               state, state_nx;
  logic [3:0]           cnt;
  logic [31:0]          mem [DEPTH];
  logic [WIDTH_MEM-1:0] wrk_idx;
  logic                 unused_bits;

  assign req_in      = {i_req_we, i_req_addr[WIDTH_MEM+1:0], i_req_data, i_req_be, i_req_tag};
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign o_req_ready = !full;
  assign push        = i_req_valid && !full;
  assign o_rsp_valid = (state == ST_RESP);
  assign wrk_idx     = wrk.addr[WIDTH_MEM+1:2];
  assign unused_bits = ^{1'b0, i_req_addr[ADDR_WIDTH-1:WIDTH_MEM+2], wrk.addr[1:0]};

`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
  assign misaligned = (wrk.addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    access   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          access   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = ST_WAIT;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Working register and wait counter; a pop always restarts the full latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrk <= '0;
      cnt <= 4'd0;
    end else if (pop) begin
      wrk <= fifo_mem[rd_ptr];
      cnt <= CNT_INIT;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers change only at the access edge, so they hold while stalled in RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_data <= 32'd0;
      o_rsp_we   <= 1'b0;
      o_rsp_tag  <= '0;
      o_rsp_err  <= 1'b0;
    end else if (access) begin
      o_rsp_data <= (wrk.we || misaligned) ? 32'd0 : mem[wrk_idx];
      o_rsp_we   <= wrk.we;
      o_rsp_tag  <= wrk.tag;
      o_rsp_err  <= misaligned;
    end
  end

  always_ff @(posedge i_clk) begin
    if (access && wrk.we && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (wrk.be[b]) mem[wrk_idx][8*b +: 8] <= wrk.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int AW  = 32;
  localparam int WM  = 6;
  localparam int TW  = 3;
  localparam int LAT = 3;
  localparam int FD  = 4;

  typedef struct packed {
    logic          we;
    logic [TW-1:0] tag;
    logic [31:0]   data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_data = 32'd0;
  logic [3:0]    req_be = 4'd0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic          rsp_we;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  bit   ready_hold = 1'b1;
  bit   measure = 1'b0;
  int   rises[$];
  exp_t sb[$];
  logic [31:0] ref_mem [1 << WM];

  dmem_responder #(
    .ADDR_WIDTH(AW), .WIDTH_MEM(WM), .WIDTH_TAG(TW), .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_data(req_data),
    .i_req_be(req_be), .i_req_tag(req_tag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_we(rsp_we), .o_rsp_tag(rsp_tag), .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks held responses stay stable.
  bit   stall_pending = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending && rsp_valid) begin
        checks++;
        if ({rsp_we, rsp_tag, rsp_data, rsp_err} !== held) begin
          errors++;
          $display("FAIL stable: got we=%0b tag=%0d data=0x%08h err=%0b held 0x%h",
                   rsp_we, rsp_tag, rsp_data, rsp_err, held);
        end
      end
      if (measure && rsp_valid && !stall_pending) rises.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp: unexpected response tag=%0d data=0x%08h", rsp_tag, rsp_data);
        end else begin
          e = sb.pop_front();
          if ({rsp_we, rsp_tag, rsp_data, rsp_err} !== e) begin
            errors++;
            $display("FAIL rsp: got we=%0b tag=%0d data=0x%08h err=%0b expected we=%0b tag=%0d data=0x%08h err=%0b",
                     rsp_we, rsp_tag, rsp_data, rsp_err, e.we, e.tag, e.data, e.err);
          end
        end
      end
      stall_pending = rsp_valid && !rsp_ready;
      held = {rsp_we, rsp_tag, rsp_data, rsp_err};
    end
  end

  // Reference model: requests are applied to the word array in issue order.
  function automatic exp_t model(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                                 input logic [3:0] be, input logic [TW-1:0] tag);
    exp_t e;
    int   idx = int'(addr[WM+1:2]);
    bit   mis = 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
    mis = (addr[1:0] != 2'b00);
`endif
    e.we = we; e.tag = tag; e.err = mis; e.data = 32'd0;
    if (!mis) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        e.data = ref_mem[idx];
      end
    end
    return e;
  endfunction

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [TW-1:0] tag);
    int n = 0;
    req_we = we; req_addr = addr; req_data = data; req_be = be; req_tag = tag;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL send_timeout: ready stuck low, expected high within 200 cycles");
    end else begin
      sb.push_back(model(we, addr, data, be, tag));
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      errors++; checks++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_tag_we_err", {27'd0, rsp_tag, rsp_we, rsp_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < (1 << WM); k++) send(1'b1, AW'(k * 4), $urandom, 4'hF, TW'(k));
    drain();

    // Store-then-load of the same word.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd1);
    send(1'b0, 32'h10, 32'd0, 4'h0, 3'd2);
    drain();
    chk("model_deadbeef", ref_mem[4], 32'hDEADBEEF);

    // Partial store merges into existing word.
    send(1'b1, 32'h24, 32'h11223344, 4'hF, 3'd3);
    send(1'b1, 32'h24, 32'h0000CAFE, 4'h3, 3'd4);
    send(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 3'd5);
    send(1'b0, 32'h24, 32'd0, 4'h0, 3'd6);
    drain();
    chk("model_cafe", ref_mem[9], 32'h1122CAFE);

    // Single-load latency: valid seen LAT+1 edges after the enqueue edge.
    begin
      int k = 0;
      send(1'b0, 32'h10, 32'd0, 4'h0, 3'd7);
      while (k < 20) begin
        @(posedge clk); #2;
        k++;
        if (rsp_valid) break;
      end
      chk("latency", 32'(k), 32'(LAT + 1));
    end
    drain();

    // Back-to-back throughput with ready held high.
    rises.delete();
    measure = 1'b1;
    for (int k = 0; k < 4; k++) send(1'b0, AW'(k * 4), 32'd0, 4'h0, TW'(k));
    drain();
    measure = 1'b0;
    chk("tput_count", 32'(rises.size()), 32'd4);
    for (int k = 1; k < rises.size(); k++) chk("tput_gap", 32'(rises[k] - rises[k-1]), 32'(LAT + 1));

    // Backpressure: four queued plus one presented fills the block.
    ready_hold = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      send(1'b0, AW'($urandom_range(0, 255)), 32'd0, 4'h0, TW'(k));
      if (k == 3) chk("bp_ready_before", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    chk("bp_ready_full", 32'(req_ready), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_ready_hold", 32'(req_ready), 32'd0);
    chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
    ready_hold = 1'b1;
    drain();

    // Reset during WAIT of a store abandons it.
    @(posedge clk);
    #1 req_we = 1'b1; req_addr = 32'h20; req_data = ~ref_mem[8]; req_be = 4'hF; req_tag = 3'd5;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_outs", rsp_data | {27'd0, rsp_tag, rsp_we, rsp_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    send(1'b0, 32'h20, 32'd0, 4'h0, 3'd6);
    drain();

    // Misaligned load.
    send(1'b0, 32'h13, 32'd0, 4'h0, 3'd2);
    drain();

    // Random traffic with random consumer backpressure and aliased addresses.
    rnd_ready = 1'b1;
    for (int k = 0; k < 250; k++)
      send(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom_range(0, 15)), TW'(k));
    rnd_ready = 1'b0;
    ready_hold = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
